ps2_kbd_ctrl: RTL and testbench

Keyboard-side controller for the PS/2 receive path. It consumes the byte stream from the PS/2 byte receiver (`rx_data` plus the `rx_done_tick` strobe) and tracks the Set-2 prefix sequences (E0 extended, F0 break, E1 Pause). It emits one normalized 10-bit key event per key action into an internal FIFO, and the CPU I/O logic reads that FIFO. Keyboard status bytes are filtered, abandoned prefix sequences are timed out, and overflow and keyboard-error conditions are reported as sticky flags.

---
 rtl/ps2_pkg.sv | 46 ++++
 rtl/ps2_evt_fifo.sv | 64 ++++++
 rtl/ps2_kbd_ctrl.sv | 157 +++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, decoder state encoding and event helpers for the PS/2
// keyboard receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_PAUSE   = 8'hE1;
  localparam logic [7:0] PS2_BAT     = 8'hAA;
  localparam logic [7:0] PS2_ECHO    = 8'hEE;
  localparam logic [7:0] PS2_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;
  localparam logic [7:0] PS2_BATFAIL = 8'hFC;

  localparam int BRK_BIT = 9;
  localparam int EXT_BIT = 8;
  localparam int EVT_W   = 10;

  localparam logic [EVT_W-1:0] PAUSE_EVT = 10'h1E1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2,
    S_SKIP = 2'd3
  } state_t;

  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ECHO) || (b == PS2_ACK) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_kbd_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BATFAIL);
  endfunction

  function automatic logic [EVT_W-1:0] make_evt(input logic brk, input logic ext,
                                               input logic [7:0] code);
    logic [EVT_W-1:0] evt;
    evt          = {2'b00, code};
    evt[BRK_BIT] = brk;
    evt[EXT_BIT] = ext;
    return evt;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; head reads as 0 while empty.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a write when a pop frees the slot this cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 Set-2 prefix decoder with prefix timeout, sticky status flags and an
// event FIFO for the CPU side. dbg_state exposes the decoder state.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       rx_data,
  input  logic             rx_done_tick,
  input  logic             rd,
  input  logic             clr_flags,
  output logic [EVT_W-1:0] key_event,
  output logic             key_valid,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             kbd_err,
  output logic [1:0]       dbg_state
);

  localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic             ext_q, ext_d;
  logic [2:0]       skip_q, skip_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             overflow_q, overflow_d;
  logic             kbd_err_q, kbd_err_d;
  logic             accept, emit, err_set, ovf_set, push;
  logic [EVT_W-1:0] evt;
  logic             fifo_full, fifo_empty;

  assign accept = rx_done_tick & en;

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    skip_d  = skip_q;
    idle_d  = idle_q;
    emit    = 1'b0;
    evt     = '0;
    err_set = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      ext_d   = 1'b0;
      skip_d  = '0;
      idle_d  = '0;
    end else if (accept) begin
      idle_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data == PS2_EXT) begin
            state_d = S_EXT;
          end else if (rx_data == PS2_BRK) begin
            state_d = S_BRK;
            ext_d   = 1'b0;
          end else if (rx_data == PS2_PAUSE) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (is_kbd_err(rx_data)) begin
            err_set = 1'b1;
          end else if (!is_status(rx_data)) begin
            emit = 1'b1;
            evt  = make_evt(1'b0, 1'b0, rx_data);
          end
        end
        S_EXT: begin
          if (rx_data == PS2_BRK) begin
            state_d = S_BRK;
            ext_d   = 1'b1;
          end else if (rx_data != PS2_EXT) begin
            emit    = 1'b1;
            evt     = make_evt(1'b0, 1'b1, rx_data);
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (rx_data != PS2_BRK && rx_data != PS2_EXT) begin
            emit    = 1'b1;
            evt     = make_evt(1'b1, ext_q, rx_data);
            state_d = S_IDLE;
            ext_d   = 1'b0;
          end
        end
        default: begin
          // Pause tail: swallow the remaining seven bytes, report once.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit    = 1'b1;
            evt     = PAUSE_EVT;
            state_d = S_IDLE;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        ext_d   = 1'b0;
        skip_d  = '0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  assign ovf_set = emit & fifo_full & ~rd;
  assign push    = emit & (~fifo_full | rd);

  always_comb begin
    overflow_d = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
    kbd_err_d  = err_set ? 1'b1 : (clr_flags ? 1'b0 : kbd_err_q);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ext_q      <= 1'b0;
      skip_q     <= '0;
      idle_q     <= '0;
      overflow_q <= 1'b0;
      kbd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      skip_q     <= skip_d;
      idle_q     <= idle_d;
      overflow_q <= overflow_d;
      kbd_err_q  <= kbd_err_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst   (rst),
    .push  (push),
    .wdata (evt),
    .pop   (rd),
    .rdata (key_event),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign overflow  = overflow_q;
  assign kbd_err   = kbd_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: a prefix-list keyboard model plus event queue is
// compared against the DUT every cycle, with literal checks at key points.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 20;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, en, rx_done_tick, rd, clr_flags;
  logic [7:0]    rx_data;
  logic [9:0]    key_event;
  logic          key_valid, overflow, kbd_err;
  logic [CW-1:0] count;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: expected FIFO contents, pending prefix bytes, flags, idle cycles.
  logic [9:0] exp_q[$];
  logic [7:0] pend[$];
  int         m_idle = 0;
  bit         m_ovf = 1'b0;
  bit         m_err = 1'b0;

  ps2_kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50     (clk),
    .rst          (rst),
    .en           (en),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .rd           (rd),
    .clr_flags    (clr_flags),
    .key_event    (key_event),
    .key_valid    (key_valid),
    .count        (count),
    .overflow     (overflow),
    .kbd_err      (kbd_err),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit         emit, err_set, ovf_set, pop, brk, ext, seen_brk;
    logic [9:0] ev;
    logic [7:0] b;
    emit = 1'b0; err_set = 1'b0; ev = '0; b = rx_data;
    if (rst) begin
      exp_q.delete(); pend.delete(); m_idle = 0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      if (!en) begin
        pend.delete(); m_idle = 0;
      end else if (rx_done_tick) begin
        m_idle = 0;
        if (pend.size() > 0 && pend[0] == 8'hE1) begin
          pend.push_back(b);
          if (pend.size() == 8) begin emit = 1'b1; ev = 10'h1E1; pend.delete(); end
        end else if (b == 8'hE0 || b == 8'hF0 || (pend.size() == 0 && b == 8'hE1)) begin
          pend.push_back(b);
        end else if (pend.size() == 0 && (b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE)) begin
          emit = 1'b0;
        end else if (pend.size() == 0 && (b == 8'h00 || b == 8'hFF || b == 8'hFC)) begin
          err_set = 1'b1;
        end else begin
          brk = 1'b0; ext = 1'b0; seen_brk = 1'b0;
          foreach (pend[i]) begin
            if (pend[i] == 8'hF0) begin brk = 1'b1; seen_brk = 1'b1; end
            if (pend[i] == 8'hE0 && !seen_brk) ext = 1'b1;
          end
          emit = 1'b1; ev = {brk, ext, b};
          pend.delete();
        end
      end else if (pend.size() > 0) begin
        if (m_idle == TIMEOUT - 1) begin pend.delete(); m_idle = 0; end
        else m_idle++;
      end
      pop     = rd && exp_q.size() > 0;
      ovf_set = emit && exp_q.size() == DEPTH && !pop;
      if (pop) void'(exp_q.pop_front());
      if (emit && !ovf_set) exp_q.push_back(ev);
      m_ovf = ovf_set ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
      m_err = err_set ? 1'b1 : (clr_flags ? 1'b0 : m_err);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", key_valid, exp_q.size() > 0);
      chk("cyc_event", key_event, exp_q.size() > 0 ? exp_q[0] : 10'h000);
      chk("cyc_count", count, exp_q.size());
      chk("cyc_overflow", overflow, m_ovf);
      chk("cyc_kbd_err", kbd_err, m_err);
      chk("cyc_idle_state", dbg_state == 2'd0, pend.size() == 0);
    end
  end

  task automatic tick(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop1();
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rx_done_tick = 1'b0; rd = 1'b0; clr_flags = 1'b0;
    rx_data = 8'h00;
    wait_cycles(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_valid", key_valid, 0);
    chk("reset_event", key_event, 0);
    chk("reset_count", count, 0);
    chk("reset_flags", {overflow, kbd_err}, 0);
    chk("reset_state", dbg_state, 0);

    // Single make code, one-cycle latency, then pop.
    tick(8'h1C);
    chk("make_event", key_event, 10'h01C);
    chk("make_valid", key_valid, 1);
    chk("make_count", count, 1);
    pop1();
    chk("pop_valid", key_valid, 0);
    chk("pop_event", key_event, 0);

    // Break and extended break with status bytes in between.
    tick(8'hF0); tick(8'h1C); tick(8'hAA); tick(8'hFA);
    tick(8'hE0); tick(8'hF0); tick(8'h75);
    chk("brk_count", count, 2);
    chk("brk_head", key_event, 10'h21C);
    pop1();
    chk("extbrk_head", key_event, 10'h375);
    pop1();

    // Pause sequence, consecutive ticks.
    tick(8'hE1); tick(8'h14); tick(8'h77); tick(8'hE1);
    tick(8'hF0); tick(8'h14); tick(8'hF0); tick(8'h77);
    chk("pause_count", count, 1);
    chk("pause_event", key_event, 10'h1E1);
    chk("pause_state", dbg_state, 0);
    pop1();

    // Overflow: 17 makes into a 16-deep FIFO.
    for (int i = 1; i <= 17; i++) tick(8'(i));
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", key_event, 10'h001);
    rd = 1'b1;
    tick(8'h12);
    rd = 1'b0;
    chk("ovf_rdpush_count", count, 16);
    chk("ovf_rdpush_head", key_event, 10'h002);
    clear_flags();
    chk("ovf_cleared", overflow, 0);
    rd = 1'b1; wait_cycles(16); rd = 1'b0;
    chk("drain_count", count, 0);

    // Prefix timeout versus just-in-time key.
    tick(8'hE0);
    wait_cycles(TIMEOUT);
    tick(8'h1C);
    chk("timeout_event", key_event, 10'h01C);
    pop1();
    tick(8'hE0);
    wait_cycles(TIMEOUT - 2);
    tick(8'h1C);
    chk("no_timeout_event", key_event, 10'h11C);
    pop1();

    // Reset mid-sequence flushes FIFO and prefix.
    tick(8'h1C); tick(8'h2A); tick(8'hF0);
    rst = 1'b1; wait_cycles(1); rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", key_valid, 0);
    tick(8'h1C);
    chk("rst_next_event", key_event, 10'h01C);
    pop1();

    // Keyboard error bytes and set-over-clear priority.
    tick(8'hFF);
    chk("err_flag", kbd_err, 1);
    chk("err_no_event", count, 0);
    clear_flags();
    chk("err_cleared", kbd_err, 0);
    clr_flags = 1'b1;
    tick(8'hFC);
    clr_flags = 1'b0;
    chk("err_set_priority", kbd_err, 1);
    clear_flags();
    tick(8'h00);
    chk("err_zero", kbd_err, 1);
    clear_flags();

    // Disable: ignored byte, and prefix abandoned by en=0.
    en = 1'b0; tick(8'hE0); en = 1'b1;
    tick(8'h1C);
    chk("en_ignored_event", key_event, 10'h01C);
    pop1();
    tick(8'hE0);
    en = 1'b0; wait_cycles(1); en = 1'b1;
    tick(8'h1C);
    chk("en_abort_event", key_event, 10'h01C);
    pop1();
    tick(8'hE0); tick(8'hE0); tick(8'h4A);
    chk("double_ext_event", key_event, 10'h14A);
    pop1();

    wait_cycles(2);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
